// File: rtl/reduction_tree_pipe.sv
// Pipelined bitwise OR/AND/XOR reduction tree, one register stage per tree level.
// Optional beat counter output o_beat_cnt is enabled by defining REDUCTION_TREE_PIPE_BEAT_CNT_EN.
module reduction_tree_pipe #(
    parameter int NUM_INPUT_DATA = 8,
    parameter int DATA_WIDTH     = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_en,
    input  logic [1:0]                           i_mode,
    input  logic [NUM_INPUT_DATA-1:0]            i_valid,
    input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] i_data_bus,
    output logic                                 o_valid,
    output logic [DATA_WIDTH-1:0]                o_data_bus
`ifdef REDUCTION_TREE_PIPE_BEAT_CNT_EN
    ,
    output logic [31:0]                          o_beat_cnt
`endif
);

    localparam int N    = NUM_INPUT_DATA;
    localparam int W    = DATA_WIDTH;
    localparam int LVLS = (N <= 2) ? 1 : $clog2(N);
    localparam int NH   = (N + 1) / 2;

    // Node count entering tree level lvl.
    function automatic int nodes_at(input int lvl);
        int n;
        n = N;
        for (int i = 0; i < lvl; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    function automatic logic [W-1:0] op_identity(input logic [1:0] mode);
        logic [W-1:0] r;
        if (mode == 2'b01) begin
            r = {W{1'b1}};
        end else begin
            r = {W{1'b0}};
        end
        return r;
    endfunction

    function automatic logic [W-1:0] op_apply(input logic [1:0] mode,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [W-1:0] r;
        case (mode)
            2'b01:   r = a & b;
            2'b10:   r = a ^ b;
            default: r = a | b;
        endcase
        return r;
    endfunction

    // Source arrays carry one spare slot so the pairing index 2j+1 never leaves range.
    logic [W-1:0] src_s      [LVLS][N+1];
    logic [1:0]   src_mode_s [LVLS];
    logic         src_bv_s   [LVLS];

    logic [W-1:0] node_d [LVLS][NH];
    logic [W-1:0] node_q [LVLS][NH];
    logic [1:0]   mode_d [LVLS];
    logic [1:0]   mode_q [LVLS];
    logic         bv_d   [LVLS];
    logic         bv_q   [LVLS];

    // Build each level's inputs: masked lanes for level 0, previous registers afterwards.
    always_comb begin
        for (int s = 0; s < LVLS; s++) begin
            for (int j = 0; j <= N; j++) begin
                src_s[s][j] = {W{1'b0}};
            end
        end
        for (int j = 0; j < N; j++) begin
            if (i_valid[j]) begin
                src_s[0][j] = i_data_bus[j*W +: W];
            end else begin
                src_s[0][j] = op_identity(i_mode);
            end
        end
        src_mode_s[0] = i_mode;
        src_bv_s[0]   = |i_valid;
        for (int s = 1; s < LVLS; s++) begin
            for (int j = 0; j < NH; j++) begin
                src_s[s][j] = node_q[s-1][j];
            end
            src_mode_s[s] = mode_q[s-1];
            src_bv_s[s]   = bv_q[s-1];
        end
    end

    // Next-state for every level: pair-combine, pass odd leftovers, or hold on stall.
    always_comb begin
        for (int s = 0; s < LVLS; s++) begin
            mode_d[s] = mode_q[s];
            bv_d[s]   = bv_q[s];
            for (int j = 0; j < NH; j++) begin
                node_d[s][j] = node_q[s][j];
            end
            if (i_en) begin
                mode_d[s] = src_mode_s[s];
                bv_d[s]   = src_bv_s[s];
                for (int j = 0; j < NH; j++) begin
                    if ((2 * j + 1) < nodes_at(s)) begin
                        node_d[s][j] = op_apply(src_mode_s[s], src_s[s][2*j], src_s[s][2*j+1]);
                    end else if ((2 * j) < nodes_at(s)) begin
                        node_d[s][j] = src_s[s][2*j];
                    end else begin
                        node_d[s][j] = {W{1'b0}};
                    end
                end
            end else begin
                mode_d[s] = mode_q[s];
            end
        end
    end

    // Stage registers; reset drops every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LVLS; s++) begin
                mode_q[s] <= 2'b00;
                bv_q[s]   <= 1'b0;
                for (int j = 0; j < NH; j++) begin
                    node_q[s][j] <= {W{1'b0}};
                end
            end
        end else begin
            for (int s = 0; s < LVLS; s++) begin
                mode_q[s] <= mode_d[s];
                bv_q[s]   <= bv_d[s];
                for (int j = 0; j < NH; j++) begin
                    node_q[s][j] <= node_d[s][j];
                end
            end
        end
    end

    assign o_valid    = bv_q[LVLS-1];
    assign o_data_bus = node_q[LVLS-1][0];

`ifdef REDUCTION_TREE_PIPE_BEAT_CNT_EN
    logic [31:0] beat_cnt_d;
    logic [31:0] beat_cnt_q;

    // Count a beat when a valid one is loaded into the final stage.
    always_comb begin
        if (i_en && src_bv_s[LVLS-1]) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= 32'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign o_beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_reduction_tree_pipe.sv
// Self-checking bench for reduction_tree_pipe (8 lanes, 1 bit, latency 3).
`timescale 1ns/1ps
module tb_reduction_tree_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_en = 1'b0;
    logic [1:0] i_mode = 2'b00;
    logic [7:0] i_valid = 8'h00;
    logic [7:0] i_data_bus = 8'h00;
    logic       o_valid;
    logic [0:0] o_data_bus;
`ifdef REDUCTION_TREE_PIPE_BEAT_CNT_EN
    logic [31:0] o_beat_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    reduction_tree_pipe #(.NUM_INPUT_DATA(8), .DATA_WIDTH(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .i_mode     (i_mode),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .o_valid    (o_valid),
`ifdef REDUCTION_TREE_PIPE_BEAT_CNT_EN
        .o_data_bus (o_data_bus),
        .o_beat_cnt (o_beat_cnt)
`else
        .o_data_bus (o_data_bus)
`endif
    );

    always #5 clk = ~clk;

    // Plain reduction of one beat from the operator rules.
    function automatic logic ref_reduce(input logic [1:0] m, input logic [7:0] v, input logic [7:0] d);
        logic r;
        r = (m == 2'b01) ? 1'b1 : 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (v[k]) begin
                case (m)
                    2'b01:   r = r & d[k];
                    2'b10:   r = r ^ d[k];
                    default: r = r | d[k];
                endcase
            end
        end
        return r;
    endfunction

    // Model: a 3-deep delay line of (valid, result) advanced on enabled edges.
    logic        m_v [3];
    logic        m_d [3];
    logic [31:0] m_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_v[i] <= 1'b0;
                m_d[i] <= 1'b0;
            end
            m_cnt <= 32'd0;
        end else if (i_en) begin
            m_v[0] <= |i_valid;
            m_d[0] <= ref_reduce(i_mode, i_valid, i_data_bus);
            m_v[1] <= m_v[0];
            m_d[1] <= m_d[0];
            m_v[2] <= m_v[1];
            m_d[2] <= m_d[1];
            if (m_v[1]) m_cnt <= m_cnt + 32'd1;
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        n_vec = n_vec + 1;
        if (o_valid !== m_v[2] || o_data_bus[0] !== m_d[2]) begin
            n_err = n_err + 1;
            $display("FAIL model_cmp t=%0t got v=%b d=%b want v=%b d=%b", $time, o_valid, o_data_bus[0], m_v[2], m_d[2]);
        end
`ifdef REDUCTION_TREE_PIPE_BEAT_CNT_EN
        n_vec = n_vec + 1;
        if (o_beat_cnt !== m_cnt) begin
            n_err = n_err + 1;
            $display("FAIL beat_cnt t=%0t got %0d want %0d", $time, o_beat_cnt, m_cnt);
        end
`endif
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] m, input logic [7:0] v, input logic [7:0] d, input logic en);
        i_mode = m;
        i_valid = v;
        i_data_bus = d;
        i_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(2'b00, 8'h00, 8'h00, 1'b1);
    endtask

    initial begin
        #1;
        lit("reset_valid", {31'd0, o_valid}, 32'd0);
        lit("reset_data", {31'd0, o_data_bus}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // OR, then all-zero beat
        step(2'b00, 8'hFF, 8'b10010010, 1'b1);
        step(2'b00, 8'hFF, 8'b00000000, 1'b1);
        idle();
        lit("or_beat1_v", {31'd0, o_valid}, 32'd1);
        lit("or_beat1_d", {31'd0, o_data_bus}, 32'd1);
        idle();
        lit("or_beat2_v", {31'd0, o_valid}, 32'd1);
        lit("or_beat2_d", {31'd0, o_data_bus}, 32'd0);
        idle();
        lit("none_valid_v", {31'd0, o_valid}, 32'd0);
        lit("none_valid_d", {31'd0, o_data_bus}, 32'd0);

        // AND with masked lanes
        step(2'b01, 8'b11110000, 8'b11110000, 1'b1);
        step(2'b01, 8'hFF, 8'b11110000, 1'b1);
        step(2'b01, 8'h00, 8'h00, 1'b1);
        lit("and_masked", {31'd0, o_data_bus}, 32'd1);
        idle();
        lit("and_full", {31'd0, o_data_bus}, 32'd0);
        idle();
        lit("and_ident_v", {31'd0, o_valid}, 32'd0);
        lit("and_ident_d", {31'd0, o_data_bus}, 32'd1);

        // Per-beat mode switching
        step(2'b10, 8'hFF, 8'b10010010, 1'b1);
        step(2'b00, 8'hFF, 8'b10001000, 1'b1);
        step(2'b10, 8'hFF, 8'b10001000, 1'b1);
        lit("xor_first", {31'd0, o_data_bus}, 32'd1);
        idle();
        lit("or_second", {31'd0, o_data_bus}, 32'd1);
        idle();
        lit("xor_even", {31'd0, o_data_bus}, 32'd0);
        lit("xor_even_v", {31'd0, o_valid}, 32'd1);

        // Stall mid-stream with garbage inputs
        step(2'b00, 8'hFF, 8'b10010010, 1'b1);
        step(2'b01, 8'hFF, 8'hFF, 1'b1);
        step(2'b01, 8'hFF, 8'h7F, 1'b1);
        lit("pre_stall", {31'd0, o_data_bus}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(2'($urandom_range(0, 3)), 8'hFF, 8'($urandom), 1'b0);
            lit("stall_v", {31'd0, o_valid}, 32'd1);
            lit("stall_d", {31'd0, o_data_bus}, 32'd1);
        end
        idle();
        lit("post_stall_b2", {31'd0, o_data_bus}, 32'd1);
        idle();
        lit("post_stall_b3", {31'd0, o_data_bus}, 32'd0);
        lit("post_stall_b3v", {31'd0, o_valid}, 32'd1);
        idle();
        lit("post_stall_end", {31'd0, o_valid}, 32'd0);

        // Reset with three beats in flight
        step(2'b00, 8'hFF, 8'hFF, 1'b1);
        step(2'b00, 8'hFF, 8'hFF, 1'b1);
        step(2'b00, 8'hFF, 8'hFF, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        lit("rst_mid_v", {31'd0, o_valid}, 32'd0);
        lit("rst_mid_d", {31'd0, o_data_bus}, 32'd0);
`ifdef REDUCTION_TREE_PIPE_BEAT_CNT_EN
        lit("rst_mid_cnt", o_beat_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(2'b10, 8'h0F, 8'h07, 1'b1);
        idle();
        lit("no_stale", {31'd0, o_valid}, 32'd0);
        idle();
        lit("first_after_rst_v", {31'd0, o_valid}, 32'd1);
        lit("first_after_rst_d", {31'd0, o_data_bus}, 32'd1);

        // Random mix, checked by the model only
        for (int i = 0; i < 40; i++) begin
            step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        repeat (4) idle();

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reduction_tree_pipe.md
REDUCTION_TREE_PIPE -- requirements
Module: reduction_tree_pipe

Interface
REQ-001 SHALL have parameter NUM_INPUT_DATA, default 8: number of input lanes; any integer >= 1.
REQ-002 SHALL have parameter DATA_WIDTH, default 1: bits per lane and per result.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_en, input, 1 bit: pipeline advance enable; 0 = stall.
REQ-006 SHALL have port i_mode, input, 2 bits: reduction operator, sampled with the input beat.
REQ-007 SHALL have port i_valid, input, NUM_INPUT_DATA bits: per-lane valid.
REQ-008 SHALL have port i_data_bus, input, NUM_INPUT_DATA*DATA_WIDTH bits: lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH], lane 0 at LSB.
REQ-009 SHALL have port o_valid, output, 1 bit: result valid.
REQ-010 SHALL have port o_data_bus, output, DATA_WIDTH bits: bitwise reduction result.
REQ-011 SHALL have port o_beat_cnt, output, 32 bits, present only when the configuration macro is defined: count of valid results emitted.

Function
REQ-012 SHALL decode i_mode as 00 = bitwise OR, 01 = bitwise AND, 10 = bitwise XOR, 11 = bitwise OR (reserved).
REQ-013 SHALL replace each lane with i_valid[k]=0 by the operator identity before reduction: all-zeros for OR/XOR, all-ones for AND.
REQ-014 SHALL reduce lanes as a binary tree with one register stage per tree level; latency L = max(1, ceil(log2(NUM_INPUT_DATA))) enabled cycles.
REQ-015 SHALL pass an odd leftover node at any level to the next level unmodified, through that level's register.
REQ-016 SHALL carry the sampled mode and a beat-valid bit alongside data through every stage, so a mode change takes effect on a per-beat basis with no mixing.
REQ-017 SHALL set the beat-valid bit to the OR of all i_valid bits; o_valid equals that bit after L enabled cycles.
REQ-018 SHALL, when all i_valid are 0, emit the identity value on o_data_bus with o_valid=0.
REQ-019 SHALL, when i_en=1, advance every stage by one level and sample a new input beat each cycle (throughput one beat per cycle).
REQ-020 SHALL, when i_en=0, hold every stage register, o_valid and o_data_bus unchanged and ignore inputs.
REQ-021 SHALL, for NUM_INPUT_DATA=1, register the masked lane 0 once (L=1).

Reset
REQ-022 SHALL, while rst_n=0, clear all stage data, mode and beat-valid registers asynchronously: o_valid=0, o_data_bus=0.
REQ-023 SHALL discard all in-flight beats on reset assertion mid-operation; the first valid output after release is the first beat sampled after release, L enabled cycles later.
REQ-024 SHALL reset o_beat_cnt to 0 when present.

Configuration
REQ-025 SHALL, with macro REDUCTION_TREE_PIPE_BEAT_CNT_EN defined, include o_beat_cnt, which increments by 1 on every rising edge where i_en=1 and the final-stage register is loaded with beat-valid=1, wrapping from 0xFFFFFFFF to 0, and holds during stall.
REQ-026 SHALL, without REDUCTION_TREE_PIPE_BEAT_CNT_EN, omit port o_beat_cnt and its counter entirely; all other behaviour identical.

Verification (NUM_INPUT_DATA=8, DATA_WIDTH=1, L=3)
REQ-027 SHALL cover: mode=00, i_valid=8'hFF, data 8'b10010010 then 8'b00000000, i_en=1 -> o_valid=1, o_data_bus=1 at cycle 3, then 0 at cycle 4.
REQ-028 SHALL cover: mode=01, i_valid=8'b11110000, data 8'b11110000 -> o_data_bus=1 (masked lanes read as 1); with i_valid=8'hFF -> 0.
REQ-029 SHALL cover: back-to-back beats mode 10 data 8'b10010010 then mode 00 data 8'b10001000 -> outputs 1 then 1 on consecutive cycles, XOR beat first; mode 10 data 8'b10001000 -> 0.
REQ-030 SHALL cover: i_valid=8'h00 -> o_valid=0, o_data_bus=0 (OR); o_beat_cnt unchanged.
REQ-031 SHALL cover: i_en=0 for 4 cycles mid-stream -> outputs frozen, no beat lost or duplicated after i_en returns to 1; o_beat_cnt counts each valid beat exactly once.
REQ-032 SHALL cover: rst_n pulsed low with 3 beats in flight -> o_valid=0, o_data_bus=0 immediately, no stale beat appears after release, o_beat_cnt=0.
